// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds it in reset, lets it run,
// then stops on halt, overflow or cycle budget and reports the cause.
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 10,
  parameter int MAX_CYCLES   = 1000,
  parameter int CNT_WIDTH    = 32,
  parameter int N_OVF        = 1,
  parameter bit STOP_ON_OVF  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_OVF-1:0]     ovf,
  input  logic                 halt_req,
  input  logic                 restart,
  output logic                 cpu_reset,
  output logic                 run_en,
  output logic                 done,
  output logic [1:0]           done_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic                 ovf_seen,
  output logic [3:0]           ovf_first_ch
);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

  localparam logic [1:0] C_HALT = 2'b01;
  localparam logic [1:0] C_OVF  = 2'b10;
  localparam logic [1:0] C_TOUT = 2'b11;

  logic [1:0]           state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 run_en_q, run_en_d;
  logic                 done_q, done_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] oc_q, oc_d;
  logic                 seen_q, seen_d;
  logic [3:0]           ch_q, ch_d;

  logic                 any_ovf;
  logic [3:0]           low_ch;
  logic                 clr;

  always_comb begin
    any_ovf = |ovf;
    low_ch  = 4'd0;
    // scan downward so the lowest set channel wins
    for (int i = N_OVF - 1; i >= 0; i--) begin
      if (ovf[i]) low_ch = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    cyc_d   = cyc_q;
    oc_d    = oc_q;
    seen_d  = seen_q;
    ch_d    = ch_q;
    clr     = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        if (restart) begin
          clr = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + CNT_WIDTH'(1);
        if (any_ovf) begin
          if (oc_q != '1) oc_d = oc_q + CNT_WIDTH'(1);
          if (!seen_q) begin
            seen_d = 1'b1;
            ch_d   = low_ch;
          end
        end
        if (restart) begin
          state_d = S_HOLD;
          clr     = 1'b1;
        end else if (halt_req) begin
          state_d = S_DONE;
          cause_d = C_HALT;
        end else if (STOP_ON_OVF && any_ovf) begin
          state_d = S_DONE;
          cause_d = C_OVF;
        end else if (cyc_q == CYC_LAST) begin
          state_d = S_DONE;
          cause_d = C_TOUT;
        end
      end
      S_DONE: begin
        if (restart) begin
          state_d = S_HOLD;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        clr     = 1'b1;
      end
    endcase
    if (clr) begin
      hold_d  = '0;
      cause_d = 2'b00;
      cyc_d   = '0;
      oc_d    = '0;
      seen_d  = 1'b0;
      ch_d    = 4'd0;
    end
    cpu_reset_d = (state_d == S_HOLD);
    run_en_d    = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
      run_en_q    <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'b00;
      cyc_q       <= '0;
      oc_q        <= '0;
      seen_q      <= 1'b0;
      ch_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
      run_en_q    <= run_en_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      cyc_q       <= cyc_d;
      oc_q        <= oc_d;
      seen_q      <= seen_d;
      ch_q        <= ch_d;
    end
  end

  assign cpu_reset    = cpu_reset_q;
  assign run_en       = run_en_q;
  assign done         = done_q;
  assign done_cause   = cause_q;
  assign cycle_count  = cyc_q;
  assign ovf_count    = oc_q;
  assign ovf_seen     = seen_q;
  assign ovf_first_ch = ch_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed scoreboard bench for cpu_run_ctrl: two instances, one
// counting overflows, one stopping on them with a short budget.
module tb_cpu_run_ctrl;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        dn;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] oc;
    logic        seen;
    logic [3:0]  ch;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_halt, a_restart;
  logic [3:0]  a_ovf;
  logic        a_cpu_reset, a_run_en, a_done, a_seen;
  logic [1:0]  a_cause;
  logic [31:0] a_cyc, a_oc;
  logic [3:0]  a_ch;

  logic        b_reset, b_halt, b_restart;
  logic [3:0]  b_ovf;
  logic        b_cpu_reset, b_run_en, b_done, b_seen;
  logic [1:0]  b_cause;
  logic [31:0] b_cyc, b_oc;
  logic [3:0]  b_ch;

  cpu_run_ctrl #(
    .RESET_CYCLES(10), .MAX_CYCLES(1000), .CNT_WIDTH(32),
    .N_OVF(4), .STOP_ON_OVF(1'b0)
  ) dut_a (
    .clk(clk), .reset(a_reset), .ovf(a_ovf),
    .halt_req(a_halt), .restart(a_restart),
    .cpu_reset(a_cpu_reset), .run_en(a_run_en), .done(a_done),
    .done_cause(a_cause), .cycle_count(a_cyc), .ovf_count(a_oc),
    .ovf_seen(a_seen), .ovf_first_ch(a_ch)
  );

  cpu_run_ctrl #(
    .RESET_CYCLES(3), .MAX_CYCLES(20), .CNT_WIDTH(32),
    .N_OVF(4), .STOP_ON_OVF(1'b1)
  ) dut_b (
    .clk(clk), .reset(b_reset), .ovf(b_ovf),
    .halt_req(b_halt), .restart(b_restart),
    .cpu_reset(b_cpu_reset), .run_en(b_run_en), .done(b_done),
    .done_cause(b_cause), .cycle_count(b_cyc), .ovf_count(b_oc),
    .ovf_seen(b_seen), .ovf_first_ch(b_ch)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic obs_t mk(bit r, bit e, bit d, int c,
                              int cy, int oc, bit s, int ch);
    obs_t o;
    o.rst   = r;
    o.run   = e;
    o.dn    = d;
    o.cause = 2'(c);
    o.cyc   = 32'(cy);
    o.oc    = 32'(oc);
    o.seen  = s;
    o.ch    = 4'(ch);
    return o;
  endfunction

  function automatic obs_t hold0();
    return mk(1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic obs_t obs(bit b);
    if (b)
      return {b_cpu_reset, b_run_en, b_done, b_cause,
              b_cyc, b_oc, b_seen, b_ch};
    return {a_cpu_reset, a_run_en, a_done, a_cause,
            a_cyc, a_oc, a_seen, a_ch};
  endfunction

  // push expectation, advance n edges, then pop and compare
  task automatic step(input bit b, input int n,
                      input string tag, input obs_t e);
    obs_t g, x;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    repeat (n) @(posedge clk);
    #1;
    g = obs(b);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (g === x) else begin
      n_bad++;
      $error("FAIL %s: got rst=%0b run=%0b done=%0b cause=%0d cyc=%0d oc=%0d seen=%0b ch=%0d required rst=%0b run=%0b done=%0b cause=%0d cyc=%0d oc=%0d seen=%0b ch=%0d",
             t, g.rst, g.run, g.dn, g.cause, g.cyc, g.oc, g.seen, g.ch,
             x.rst, x.run, x.dn, x.cause, x.cyc, x.oc, x.seen, x.ch);
    end
  endtask

  initial begin
    a_reset = 1; a_halt = 0; a_restart = 0; a_ovf = 4'b0000;
    b_reset = 1; b_halt = 0; b_restart = 0; b_ovf = 4'b0000;

    step(0, 10, "a_reset", hold0());
    a_reset = 0;
    step(0, 9, "a_hold_last", hold0());
    step(0, 1, "a_run_first", mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(0, 3, "a_run3", mk(0, 1, 0, 0, 3, 0, 0, 0));
    a_ovf = 4'b0110;
    step(0, 1, "a_ovf1", mk(0, 1, 0, 0, 4, 1, 1, 1));
    a_ovf = 4'b0000;
    step(0, 3, "a_run7", mk(0, 1, 0, 0, 7, 1, 1, 1));
    a_ovf = 4'b0001;
    step(0, 1, "a_ovf2", mk(0, 1, 0, 0, 8, 2, 1, 1));
    a_ovf = 4'b0000;
    step(0, 991, "a_pre_tout", mk(0, 1, 0, 0, 999, 2, 1, 1));
    step(0, 1, "a_tout", mk(0, 0, 1, 3, 1000, 2, 1, 1));
    a_ovf = 4'b1111; a_halt = 1;
    step(0, 2, "a_done_frz", mk(0, 0, 1, 3, 1000, 2, 1, 1));
    a_ovf = 4'b0000; a_halt = 0; a_restart = 1;
    step(0, 1, "a_rst_done", hold0());
    a_restart = 0;
    step(0, 9, "a_hold2", hold0());
    step(0, 1, "a_run2", mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(0, 5, "a_run5", mk(0, 1, 0, 0, 5, 0, 0, 0));
    a_halt = 1;
    step(0, 1, "a_halt", mk(0, 0, 1, 1, 6, 0, 0, 0));
    a_halt = 0; a_restart = 1;
    step(0, 1, "a_rs1", hold0());
    a_restart = 0;
    step(0, 4, "a_hold4", hold0());
    a_restart = 1;
    step(0, 1, "a_rs_hold", hold0());
    a_restart = 0;
    step(0, 9, "a_hold_re", hold0());
    step(0, 1, "a_run3rd", mk(0, 1, 0, 0, 0, 0, 0, 0));
    a_ovf = 4'b0100;
    step(0, 1, "a_ovf_ch2", mk(0, 1, 0, 0, 1, 1, 1, 2));
    a_ovf = 4'b0000; a_restart = 1;
    step(0, 1, "a_rs_run", hold0());
    a_restart = 0;
    step(0, 10, "a_run4th", mk(0, 1, 0, 0, 0, 0, 0, 0));
    a_ovf = 4'b1000;
    step(0, 4, "a_ovf_ch3", mk(0, 1, 0, 0, 4, 4, 1, 3));
    a_reset = 1; a_restart = 1;
    step(0, 1, "a_rst_mid", hold0());
    a_reset = 0; a_restart = 0; a_ovf = 4'b0000;
    step(0, 9, "a_hold5", hold0());
    step(0, 1, "a_run5th", mk(0, 1, 0, 0, 0, 0, 0, 0));

    step(1, 2, "b_reset", hold0());
    b_reset = 0;
    step(1, 2, "b_hold_last", hold0());
    step(1, 1, "b_run_first", mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(1, 2, "b_run2", mk(0, 1, 0, 0, 2, 0, 0, 0));
    b_ovf = 4'b0010; b_halt = 1;
    step(1, 1, "b_halt_ovf", mk(0, 0, 1, 1, 3, 1, 1, 1));
    b_ovf = 4'b0000; b_halt = 0; b_restart = 1;
    step(1, 1, "b_rs", hold0());
    b_restart = 0;
    step(1, 3, "b_run_r", mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(1, 1, "b_run1", mk(0, 1, 0, 0, 1, 0, 0, 0));
    b_ovf = 4'b1000;
    step(1, 1, "b_ovf_stop", mk(0, 0, 1, 2, 2, 1, 1, 3));
    b_ovf = 4'b0000; b_restart = 1;
    step(1, 1, "b_rs2", hold0());
    b_restart = 0;
    step(1, 3, "b_run_r2", mk(0, 1, 0, 0, 0, 0, 0, 0));
    b_restart = 1; b_halt = 1; b_ovf = 4'b0001;
    step(1, 1, "b_rs_prio", hold0());
    b_restart = 0; b_halt = 0; b_ovf = 4'b0000;
    step(1, 3, "b_run_r3", mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(1, 19, "b_pre_tout", mk(0, 1, 0, 0, 19, 0, 0, 0));
    step(1, 1, "b_tout", mk(0, 0, 1, 3, 20, 0, 0, 0));
    b_reset = 1;
    step(1, 1, "b_rst_done", hold0());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 10, meaning clock cycles cpu_reset is held after reset release; legal range is 1 or more.
REQ-002 The block SHALL have parameter MAX_CYCLES, default 1000, meaning the RUN-cycle budget before timeout; legal range is 1 to 2^CNT_WIDTH-1.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 32, meaning the width of cycle_count and ovf_count.
REQ-004 The block SHALL have parameter N_OVF, default 1, meaning the number of monitored overflow channels; legal range is 1 to 16.
REQ-005 The block SHALL have parameter STOP_ON_OVF, default 0: 1 halts on the first overflow, 0 counts overflows and continues.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ovf  input  N_OVF  per-channel overflow flags from the CPU(s), sampled each RUN cycle.
REQ-009 halt_req  input  1  level request to stop the run, sampled in RUN.
REQ-010 restart  input  1  single-cycle pulse that starts a new run.
REQ-011 cpu_reset  output  1  registered reset to the CPU under control.
REQ-012 run_en  output  1  registered CPU clock-enable, high only in RUN.
REQ-013 done  output  1  high while in the DONE state.
REQ-014 done_cause  output  2  stop reason: 00 none, 01 halt, 10 ovf, 11 timeout.
REQ-015 cycle_count  output  CNT_WIDTH  number of RUN cycles elapsed.
REQ-016 ovf_count  output  CNT_WIDTH  number of RUN cycles with any ovf bit set.
REQ-017 ovf_seen  output  1  sticky flag: at least one overflow seen this run.
REQ-018 ovf_first_ch  output  4  lowest set channel index of the first overflow cycle.

Function
REQ-019 The block SHALL implement three states: HOLD, RUN and DONE; all outputs SHALL be registered.
REQ-020 On entering HOLD, the block SHALL clear cycle_count, ovf_count, ovf_seen, ovf_first_ch, done_cause and the hold counter.
REQ-021 HOLD SHALL drive cpu_reset=1, run_en=0 and done=0.
REQ-022 HOLD SHALL last exactly RESET_CYCLES clock cycles, then move to RUN.
REQ-023 The first RUN cycle SHALL show cpu_reset=0 and run_en=1.
REQ-024 In RUN, cycle_count SHALL increment by 1 each cycle.
REQ-025 In RUN, when any ovf bit is 1, the block SHALL increment ovf_count, saturating at all-ones.
REQ-026 On the first overflow cycle of a run only, the block SHALL set ovf_seen and latch ovf_first_ch to the lowest set bit index.
REQ-027 The RUN exit check SHALL be evaluated each cycle in this priority order: restart, then halt_req, then an overflow when STOP_ON_OVF=1, then cycle_count == MAX_CYCLES-1.
REQ-028 On restart in RUN, the block SHALL move to HOLD, aborting the run.
REQ-029 On halt_req in RUN, the block SHALL move to DONE with done_cause=01.
REQ-030 On an overflow in RUN with STOP_ON_OVF=1, the block SHALL move to DONE with done_cause=10.
REQ-031 When cycle_count == MAX_CYCLES-1 in RUN, the block SHALL move to DONE with done_cause=11.
REQ-032 The exiting RUN cycle SHALL itself be counted in cycle_count, and in ovf_count when ovf is set.
REQ-033 DONE SHALL drive done=1, run_en=0 and cpu_reset=0, and SHALL freeze all counters and flags.
REQ-034 DONE SHALL ignore ovf and halt_req.
REQ-035 On restart in DONE, the block SHALL move to HOLD.
REQ-036 A restart during HOLD SHALL restart the hold count from 0.
REQ-037 With STOP_ON_OVF=0, an overflow SHALL never stop the run.

Reset
REQ-038 While reset=1, the block SHALL force HOLD with the hold counter at 0, cpu_reset=1, run_en=0, done=0, done_cause=00, both counters at 0, ovf_seen=0 and ovf_first_ch=0.
REQ-039 reset SHALL have priority over restart and all other inputs, including when asserted in the middle of RUN or DONE.
REQ-040 Counting of the RESET_CYCLES hold period SHALL begin on the first edge with reset=0.

Verification
REQ-041 Defaults, reset held 10 cycles then released, no ovf, halt_req=0 -> cpu_reset low after 10 cycles; done=1 and done_cause=11 with cycle_count=1000 at DONE.
REQ-042 halt_req pulsed in RUN cycle 5 -> next cycle done=1, done_cause=01, cycle_count=6, run_en=0.
REQ-043 N_OVF=4, STOP_ON_OVF=0, ovf=4'b0110 in RUN cycle 3 and 4'b0001 in cycle 7 -> ovf_count=2, ovf_seen=1, ovf_first_ch=1, run continues.
REQ-044 STOP_ON_OVF=1 with ovf and halt_req both high in the same cycle -> done_cause=01 and ovf_count incremented by 1.
REQ-045 restart in DONE -> RESET_CYCLES cycles with cpu_reset=1 and all counters at 0, then RUN resumes.
REQ-046 reset asserted in the middle of RUN -> next edge gives cpu_reset=1, counters 0, state HOLD.
